// File: rtl/sprite_mover.sv
// sprite_mover: single-sprite motion engine and pixel renderer for the OLED pipeline.
// Step timing uses a clock-enable counter in the one clk domain.
module sprite_mover #(
    parameter int unsigned SCR_W      = 96,
    parameter int unsigned SCR_H      = 64,
    parameter int unsigned IDX_W      = 13,
    parameter int unsigned POS_W      = 8,
    parameter int unsigned SPR_SIZE   = 5,
    parameter int unsigned START_X    = 46,
    parameter int unsigned START_Y    = 59,
    parameter int unsigned DIV_FAST   = 2222221,
    parameter int unsigned DIV_SLOW   = 6666665,
    parameter logic [15:0] COL_IDLE   = 16'h001F,
    parameter logic [15:0] COL_ACTIVE = 16'hFFFF,
    parameter logic [15:0] COL_BG     = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             speed_sel,
    input  logic             btnC,
    input  logic             btnU,
    input  logic             btnD,
    input  logic             btnL,
    input  logic             btnR,
    input  logic [IDX_W-1:0] pixel_index,
    output logic [15:0]      pixel_data,
    output logic [POS_W-1:0] sprite_x,
    output logic [POS_W-1:0] sprite_y,
    output logic             moving,
    output logic [1:0]       state
);

    localparam int unsigned DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
    localparam int unsigned CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int unsigned CMP_W   = POS_W + 1;

    localparam logic [POS_W-1:0] X_MAX   = POS_W'(SCR_W - SPR_SIZE);
    localparam logic [POS_W-1:0] Y_MAX   = POS_W'(SCR_H - SPR_SIZE);
    localparam logic [POS_W-1:0] X_START = POS_W'(START_X);
    localparam logic [POS_W-1:0] Y_START = POS_W'(START_Y);
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(DIV_FAST - 1);
    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(DIV_SLOW - 1);
    localparam logic [IDX_W-1:0] PIX_CNT   = IDX_W'(SCR_W * SCR_H);
    localparam logic [IDX_W-1:0] IDX_SCR_W = IDX_W'(SCR_W);
    localparam logic [CMP_W-1:0] SPR_EXT   = CMP_W'(SPR_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STOP = 2'b01,
        ST_MOVE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spd_q, spd_d;
    logic [15:0]      pix_q, pix_d;
    logic             moving_q, moving_d;

    logic             btn_any;
    dir_e             btn_dir;
    logic [CNT_W-1:0] cnt_last;
    logic             spd_chg;
    logic             tick;
    logic [POS_W-1:0] step_x, step_y;

    logic [CMP_W-1:0] pix_x, pix_y, spr_x, spr_y;
    logic             hit;

    // True when the sprite already touches the screen edge in direction d
    function automatic logic at_edge(input dir_e d, input logic [POS_W-1:0] px,
                                     input logic [POS_W-1:0] py);
        logic r;
        case (d)
            DIR_UP:   r = (py == '0);
            DIR_DOWN: r = (py == Y_MAX);
            DIR_LEFT: r = (px == '0);
            default:  r = (px == X_MAX);
        endcase
        return r;
    endfunction

    // Direction request decode (U > D > L > R) and step-enable generation
    always_comb begin
        btn_any = btnU | btnD | btnL | btnR;
        if (btnU)      btn_dir = DIR_UP;
        else if (btnD) btn_dir = DIR_DOWN;
        else if (btnL) btn_dir = DIR_LEFT;
        else           btn_dir = DIR_RIGHT;

        cnt_last = speed_sel ? LAST_SLOW : LAST_FAST;
        spd_chg  = (speed_sel != spd_q);
        tick     = (state_q == ST_MOVE) && !spd_chg && (cnt_q == cnt_last);
    end

    // One-pixel step in the latched direction, saturating at the edges
    always_comb begin
        step_x = x_q;
        step_y = y_q;
        case (dir_q)
            DIR_UP:    if (y_q != '0)    step_y = y_q - 1'b1;
            DIR_DOWN:  if (y_q != Y_MAX) step_y = y_q + 1'b1;
            DIR_LEFT:  if (x_q != '0)    step_x = x_q - 1'b1;
            default:   if (x_q != X_MAX) step_x = x_q + 1'b1;
        endcase
    end

    // Next-state, position, direction and step counter
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        cnt_d   = '0;
        spd_d   = speed_sel;

        if (!enable) begin
            state_d = ST_IDLE;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btnC) begin
                        state_d = ST_STOP;
                        x_d     = X_START;
                        y_d     = Y_START;
                    end
                end
                ST_STOP: begin
                    if (btnC) begin
                        x_d = X_START;
                        y_d = Y_START;
                    end else if (btn_any && !at_edge(btn_dir, x_q, y_q)) begin
                        state_d = ST_MOVE;
                        dir_d   = btn_dir;
                    end
                end
                ST_MOVE: begin
                    if (!spd_chg && (cnt_q != cnt_last)) cnt_d = cnt_q + 1'b1;
                    if (btn_any && !at_edge(btn_dir, x_q, y_q)) dir_d = btn_dir;
                    if (tick) begin
                        x_d = step_x;
                        y_d = step_y;
                        if (at_edge(dir_q, step_x, step_y)) state_d = ST_STOP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        moving_d = (state_d == ST_MOVE);
    end

    // Pixel colour for the requested index using the current position
    always_comb begin
        pix_x = CMP_W'(pixel_index % IDX_SCR_W);
        pix_y = CMP_W'(pixel_index / IDX_SCR_W);
        spr_x = {1'b0, x_q};
        spr_y = {1'b0, y_q};
        hit   = (pixel_index < PIX_CNT) &&
                (pix_x >= spr_x) && (pix_x < spr_x + SPR_EXT) &&
                (pix_y >= spr_y) && (pix_y < spr_y + SPR_EXT);
        if (!hit)                      pix_d = COL_BG;
        else if (state_q == ST_IDLE)   pix_d = COL_IDLE;
        else                           pix_d = COL_ACTIVE;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_UP;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            spd_q    <= 1'b0;
            pix_q    <= COL_BG;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            spd_q    <= spd_d;
            pix_q    <= pix_d;
            moving_q <= moving_d;
        end
    end

    assign pixel_data = pix_q;
    assign sprite_x   = x_q;
    assign sprite_y   = y_q;
    assign moving     = moving_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: reference model + pixel scoreboard for sprite_mover (short dividers).
module tb_sprite_mover;

    localparam int SCR_W = 96;
    localparam int SCR_H = 64;
    localparam int IDX_W = 13;
    localparam int POS_W = 8;
    localparam int SPR   = 5;
    localparam int SX    = 46;
    localparam int SY    = 59;
    localparam int DF    = 4;
    localparam int DS    = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             speed_sel = 1'b0;
    logic             btnC = 1'b0, btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic [IDX_W-1:0] pixel_index = '0;
    logic [15:0]      pixel_data;
    logic [POS_W-1:0] sprite_x, sprite_y;
    logic             moving;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    sprite_mover #(.DIV_FAST(DF), .DIV_SLOW(DS)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .speed_sel  (speed_sel),
        .btnC       (btnC),
        .btnU       (btnU),
        .btnD       (btnD),
        .btnL       (btnL),
        .btnR       (btnR),
        .pixel_index(pixel_index),
        .pixel_data (pixel_data),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .moving     (moving),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state: st 0 IDLE/1 STOP/2 MOVE, dir 0 U/1 D/2 L/3 R
    int        m_st = 0, m_x = 0, m_y = 0, m_dir = 0, m_cnt = 0;
    logic      m_spd = 1'b0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] ref_pixel(input int idx, input int st, input int sx, input int sy);
        int px, py;
        if (idx >= SCR_W * SCR_H) return 16'h0000;
        px = idx % SCR_W;
        py = idx / SCR_W;
        if (px >= sx && px < sx + SPR && py >= sy && py < sy + SPR)
            return (st == 0) ? 16'h001F : 16'hFFFF;
        return 16'h0000;
    endfunction

    function automatic bit blocked(input int d, input int x, input int y);
        case (d)
            0:       return y == 0;
            1:       return y == SCR_H - SPR;
            2:       return x == 0;
            default: return x == SCR_W - SPR;
        endcase
    endfunction

    task automatic model_step();
        int req, div, od;
        bit tk;
        exp_q.push_back(ref_pixel(int'(pixel_index), m_st, m_x, m_y));
        req = btnU ? 0 : btnD ? 1 : btnL ? 2 : btnR ? 3 : -1;
        div = speed_sel ? DS : DF;
        tk  = (m_st == 2) && (speed_sel == m_spd) && (m_cnt == div - 1);
        if (m_st == 2 && speed_sel == m_spd) m_cnt = (m_cnt + 1) % div;
        else                                 m_cnt = 0;
        m_spd = speed_sel;
        od = m_dir;
        if (!enable) begin
            m_st = 0; m_x = 0; m_y = 0; m_cnt = 0;
        end else if (m_st == 0) begin
            if (btnC) begin m_st = 1; m_x = SX; m_y = SY; end
        end else if (m_st == 1) begin
            if (btnC) begin
                m_x = SX; m_y = SY;
            end else if (req >= 0 && !blocked(req, m_x, m_y)) begin
                m_st = 2; m_dir = req;
            end
        end else begin
            if (req >= 0 && !blocked(req, m_x, m_y)) m_dir = req;
            if (tk) begin
                case (od)
                    0:       m_y = m_y - 1;
                    1:       m_y = m_y + 1;
                    2:       m_x = m_x - 1;
                    default: m_x = m_x + 1;
                endcase
                if (blocked(od, m_x, m_y)) begin m_st = 1; m_cnt = 0; end
            end
        end
    endtask

    // Model advances on the same edges as the DUT; async reset clears it and the scoreboard
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 0; m_x = 0; m_y = 0; m_dir = 0; m_cnt = 0; m_spd = 1'b0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // Compare DUT against model and pop the pixel scoreboard on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            check("mdl_state", 32'(state), 32'(m_st));
            check("mdl_x", 32'(sprite_x), 32'(m_x));
            check("mdl_y", 32'(sprite_y), 32'(m_y));
            check("mdl_moving", 32'(moving), 32'(m_st == 2));
            if (exp_q.size() > 0) check("sb_pixel", 32'(pixel_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_x", 32'(sprite_x), 32'd0);
        check("rst_y", 32'(sprite_y), 32'd0);
        check("rst_px", 32'(pixel_data), 32'h0000);
        check("rst_moving", 32'(moving), 32'd0);

        reset = 1'b0; enable = 1'b1; pixel_index = 13'd0;
        tick(1);
        check("idle_px0", 32'(pixel_data), 32'h001F);
        pixel_index = 13'd5;
        tick(1);
        check("idle_px5", 32'(pixel_data), 32'h0000);
        check("idle_state", 32'(state), 32'd0);
        btnU = 1'b1; btnR = 1'b1;
        tick(1);
        btnU = 1'b0; btnR = 1'b0;
        check("idle_ignore_dir", 32'(state), 32'd0);

        btnC = 1'b1; tick(1); btnC = 1'b0;
        check("arm_state", 32'(state), 32'd1);
        check("arm_x", 32'(sprite_x), 32'd46);
        check("arm_y", 32'(sprite_y), 32'd59);
        pixel_index = 13'd5710; tick(1);
        check("arm_px_hit", 32'(pixel_data), 32'hFFFF);
        pixel_index = 13'd5715; tick(1);
        check("arm_px_miss", 32'(pixel_data), 32'h0000);

        // Right at fast speed to the right edge
        btnR = 1'b1; tick(1); btnR = 1'b0;
        check("right_moving", 32'(moving), 32'd1);
        for (int i = 1; i <= 45; i++) begin
            tick(4);
            check("right_x", 32'(sprite_x), 32'(46 + i));
        end
        check("right_edge_state", 32'(state), 32'd1);
        check("right_edge_moving", 32'(moving), 32'd0);
        tick(100);
        check("right_hold_x", 32'(sprite_x), 32'd91);
        check("right_hold_state", 32'(state), 32'd1);

        // Up at slow speed, then re-latch left mid-period, then U+R -> up
        btnC = 1'b1; tick(1); btnC = 1'b0;
        check("reload_x", 32'(sprite_x), 32'd46);
        speed_sel = 1'b1; btnU = 1'b1; tick(1); btnU = 1'b0;
        tick(12);
        check("up_y1", 32'(sprite_y), 32'd58);
        tick(12);
        check("up_y2", 32'(sprite_y), 32'd57);
        tick(5);
        btnL = 1'b1; tick(1); btnL = 1'b0;
        check("left_latch_x", 32'(sprite_x), 32'd46);
        tick(6);
        check("left_x1", 32'(sprite_x), 32'd45);
        check("left_y_hold", 32'(sprite_y), 32'd57);
        tick(12);
        check("left_x2", 32'(sprite_x), 32'd44);
        btnU = 1'b1; btnR = 1'b1; tick(1); btnU = 1'b0; btnR = 1'b0;
        tick(11);
        check("ur_prio_y", 32'(sprite_y), 32'd56);
        check("ur_prio_x", 32'(sprite_x), 32'd44);
        btnC = 1'b1; tick(1); btnC = 1'b0;
        check("move_btnc_state", 32'(state), 32'd2);
        check("move_btnc_y", 32'(sprite_y), 32'd56);
        enable = 1'b0; tick(1);
        check("dis_state", 32'(state), 32'd0);
        check("dis_x", 32'(sprite_x), 32'd0);
        check("dis_y", 32'(sprite_y), 32'd0);
        enable = 1'b1;

        // Async reset in the middle of a step period
        btnC = 1'b1; tick(1); btnC = 1'b0;
        speed_sel = 1'b0; btnR = 1'b1; tick(1); btnR = 1'b0;
        tick(6);
        check("pre_rst_x", 32'(sprite_x), 32'd47);
        #2 reset = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_x", 32'(sprite_x), 32'd0);
        check("arst_y", 32'(sprite_y), 32'd0);
        check("arst_moving", 32'(moving), 32'd0);
        check("arst_px", 32'(pixel_data), 32'h0000);
        tick(1);
        reset = 1'b0;

        // Edge-blocked direction buttons in STOP
        btnC = 1'b1; tick(1); btnC = 1'b0;
        btnD = 1'b1; tick(1); btnD = 1'b0;
        check("down_blocked_state", 32'(state), 32'd1);
        check("down_blocked_y", 32'(sprite_y), 32'd59);
        btnU = 1'b1; tick(1); btnU = 1'b0;
        for (int i = 0; i < 400 && state != 2'b01; i++) tick(1);
        check("top_arrive_state", 32'(state), 32'd1);
        check("top_arrive_y", 32'(sprite_y), 32'd0);
        btnU = 1'b1; tick(1); btnU = 1'b0;
        check("up_blocked_state", 32'(state), 32'd1);
        pixel_index = 13'd46; tick(1);
        check("top_px_hit", 32'(pixel_data), 32'hFFFF);
        pixel_index = 13'd6143; tick(1);
        check("last_px", 32'(pixel_data), 32'h0000);
        pixel_index = 13'd6144; tick(1);
        check("oob_px", 32'(pixel_data), 32'h0000);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
